// File: rtl/retire_trace_buffer_pkg.sv
// Types and constants shared by the retire trace buffer and its FIFO.
package retire_trace_buffer_pkg;
`include "dbg_trace_defs.vh"

  localparam logic [7:0] HDR_RETIRE   = `DBG_HDR_RETIRE;
  localparam logic [7:0] HDR_HALT     = `DBG_HDR_HALT;
  localparam int         RECORD_BYTES = `DBG_RECORD_BYTES;
  localparam int         RECORD_W     = `DBG_RECORD_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_e;

  // Record is packed with the first byte to send in the top bits.
  function automatic logic [RECORD_W-1:0] pack_record(
    input logic        halt_event,
    input logic [15:0] pc,
    input logic [3:0]  flags,
    input logic [7:0]  reg_a,
    input logic [7:0]  reg_b,
    input logic [7:0]  reg_c
  );
    logic [7:0] hdr;
    hdr = halt_event ? HDR_HALT : HDR_RETIRE;
    return {hdr, pc, flags, 4'h0, reg_a, reg_b, reg_c};
  endfunction
endpackage

// File: rtl/retire_trace_buffer_if.sv
// Push/pop handshake between a FIFO user (master) and the FIFO (slave).
interface retire_trace_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  modport master (output push, pop, wdata, input rdata, full, empty, count);
  modport slave  (input push, pop, wdata, output rdata, full, empty, count);
endinterface

// File: rtl/dbg_trace_defs.vh
// Shared trace record constants: header codes and record geometry.
`ifndef DBG_TRACE_DEFS_VH
`define DBG_TRACE_DEFS_VH

`define DBG_HDR_RETIRE   8'hA5
`define DBG_HDR_HALT     8'h5A
`define DBG_RECORD_BYTES 7
`define DBG_RECORD_W     56

`endif

// File: rtl/retire_trace_buffer_fifo.sv
// trace_fifo: synchronous FIFO with explicit occupancy count.
// Head entry is visible combinationally so the consumer can load it at the
// same edge it pops (first-word fall-through).
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  retire_trace_buffer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign bus.full  = (count_q == CW'(DEPTH));
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;
  assign bus.rdata = mem_q[rd_ptr_q];

  // A push while full is only taken when the head leaves in the same cycle.
  assign do_pop  = bus.pop && !bus.empty;
  assign do_push = bus.push && (!bus.full || do_pop);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: captures CPU state on retire / halt-rise into 7-byte
// records, queues them, and serializes them as a valid/ready byte stream.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] dbg_pc,
  input  logic [3:0]  dbg_F,
  input  logic [7:0]  dbg_A,
  input  logic [7:0]  dbg_B,
  input  logic [7:0]  dbg_C,
  input  logic        dbg_instruction_retired,
  input  logic        dbg_halted,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [7:0]  drop_count
);
  localparam logic [2:0] LAST_IDX = 3'(RECORD_BYTES - 1);

  retire_trace_buffer_if #(.WIDTH(RECORD_W), .DEPTH(DEPTH)) fifo_bus ();

  trace_fifo #(.WIDTH(RECORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .bus   (fifo_bus)
  );

  ser_state_e          state_q, state_d;
  logic [RECORD_W-1:0] shreg_q;
  logic [2:0]          idx_q;
  logic                halted_q;
  logic                overflow_q;
  logic [7:0]          drop_q;
  logic                halt_rise, capture, accept, last_accept, load, drop;

  assign halt_rise   = dbg_halted && !halted_q;
  assign capture     = enable && (dbg_instruction_retired || halt_rise);
  assign accept      = (state_q == S_SEND) && out_ready;
  assign last_accept = accept && (idx_q == LAST_IDX);
  // Load from IDLE, or chain straight into the next record after the last byte.
  assign load        = !fifo_bus.empty && ((state_q == S_IDLE) || last_accept);
  assign drop        = capture && fifo_bus.full && !load;

  assign fifo_bus.push  = capture;
  assign fifo_bus.pop   = load;
  assign fifo_bus.wdata = pack_record(halt_rise, dbg_pc, dbg_F, dbg_A, dbg_B, dbg_C);

  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  // Halt history resets high so a CPU already halted at reset is not traced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted_q <= 1'b1;
    else       halted_q <= dbg_halted;
  end

  // Serializer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Serializer next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_SEND;
      S_SEND:  if (last_accept && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Serializer outputs: current byte is always the top of the shift register.
  always_comb begin
    out_valid = (state_q == S_SEND);
    out_data  = out_valid ? shreg_q[RECORD_W-1 -: 8] : 8'h00;
  end

  // Shift register and byte index; both hold while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      shreg_q <= fifo_bus.rdata;
      idx_q   <= '0;
    end else if (accept) begin
      shreg_q <= {shreg_q[RECORD_W-9:0], 8'h00};
      idx_q   <= last_accept ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end
endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning record FIFO depth; power of two, at least 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  capture enable; low suppresses new records.
REQ-005 SHALL have port dbg_pc  input  16  CPU program counter.
REQ-006 SHALL have port dbg_F  input  4  CPU flags Z,N,H,C.
REQ-007 SHALL have ports dbg_A, dbg_B, dbg_C  input  8 each  CPU registers.
REQ-008 SHALL have port dbg_instruction_retired  input  1  one-cycle retire strobe.
REQ-009 SHALL have port dbg_halted  input  1  CPU halted level.
REQ-010 SHALL have port out_data  output  8  serialized trace byte.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts byte.
REQ-013 SHALL have port overflow  output  1  sticky: at least one record dropped.
REQ-014 SHALL have port drop_count  output  8  dropped records, saturating at 255.

Function
REQ-015 SHALL form a capture event in a cycle where enable=1 and (dbg_instruction_retired=1 or a halt rising edge, i.e. dbg_halted=1 and registered prior dbg_halted=0).
REQ-016 SHALL build a 7-byte record in send order: header, dbg_pc[15:8], dbg_pc[7:0], {dbg_F,4'h0}, dbg_A, dbg_B, dbg_C.
REQ-017 SHALL use header 0xA5 for retire-only events and 0x5A for any event including a halt rising edge (retire and halt rising edge in the same cycle: one record, header 0x5A).
REQ-018 SHALL write the record into the FIFO at the sampling edge; at most one write per cycle.
REQ-019 SHALL, when the FIFO is full and no pop occurs in that cycle, drop the record, set overflow and increment drop_count (saturating).
REQ-020 SHALL accept a write when full if a pop occurs in the same cycle; count stays DEPTH.
REQ-021 SHALL implement serializer FSM states IDLE and SEND with byte index 0..6.
REQ-022 IDLE: if FIFO non-empty, pop head into shift register, index=0, go to SEND at that edge.
REQ-023 SEND: out_valid=1, out_data=byte[index]; on out_valid&&out_ready, index+1; out_data and out_valid SHALL hold stable while out_ready=0.
REQ-024 SHALL, on acceptance of byte 6, pop and load the next record in the same edge if the FIFO is non-empty (back-to-back, no idle cycle), else go to IDLE.
REQ-025 Latency: capture at edge k into an empty FIFO with the serializer in IDLE -> out_valid=1 with header byte after edge k+1.
REQ-026 SHALL still serialize queued records while enable=0.
REQ-027 SHALL maintain FIFO pointers modulo DEPTH with an explicit count (0..DEPTH) for full/empty.

Reset
REQ-028 SHALL, on reset=1, immediately clear FIFO count and pointers, FSM to IDLE, index=0, out_valid=0, out_data=0x00, overflow=0, drop_count=0, halted history=1 (no spurious halt record on the first cycle after reset).
REQ-029 SHALL discard any partly sent record on reset mid-operation; no byte resumes after release.

Structure
REQ-030 SHALL take header constants (0xA5, 0x5A), RECORD_BYTES=7 and record width 56 from a shared include file dbg_trace_defs.vh.
REQ-031 SHALL instantiate one sub-module trace_fifo (parameterized width/depth synchronous FIFO with push, pop, full, empty, count).

Verification
REQ-032 Single retire, pc=0x0150, F=4'b1010, A=0x01, B=0x02, C=0x03, out_ready=1 -> bytes A5 01 50 A0 01 02 03 on consecutive cycles, first 2 edges after the strobe.
REQ-033 Retire and halt rise in the same cycle -> exactly one record, header 0x5A; halted held high afterwards -> no further halt records.
REQ-034 out_ready=0, 10 retires with DEPTH=8 -> 9 records queued (8 FIFO + 1 in shift register), overflow=1, drop_count=1; then out_ready=1 -> 63 bytes in order.
REQ-035 out_ready toggling every cycle -> each byte held stable until accepted; no byte lost or duplicated.
REQ-036 reset asserted asynchronously after byte 3 of a record -> out_valid=0 at once; after release, idle until the next capture.
REQ-037 enable=0 with retire strobes -> no records; records queued earlier still drain.
